cpu_trace_buffer: RTL



---
 rtl/cpu_trace_pkg.sv | 39 +++
 rtl/cpu_trace_buffer_ram.sv | 47 ++++
 rtl/cpu_trace_buffer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg
// Shared definitions for the CPU instruction-trace buffer: capture state
// encodings, trigger mode codes, the trace entry width and the bit offsets
// of each field inside a packed entry.
// No ports (package).
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_TRIGGERED = 2'd2,
    ST_DONE      = 2'd3
  } trace_state_e;

  localparam logic [1:0] TRIG_IMMEDIATE = 2'd0;
  localparam logic [1:0] TRIG_PC        = 2'd1;
  localparam logic [1:0] TRIG_STORE     = 2'd2;
  localparam logic [1:0] TRIG_REG       = 2'd3;

  // Entry layout, MSB first: {pc[31:0], inst[31:0], regwen, rd[3:0], wbdata[31:0]}
  localparam int ENTRY_W    = 101;
  localparam int RD_W       = 4;
  localparam int WB_LSB     = 0;
  localparam int RD_LSB     = 32;
  localparam int REGWEN_BIT = 36;
  localparam int INST_LSB   = 37;
  localparam int PC_LSB     = 69;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [31:0]     pc,
    input logic [31:0]     inst,
    input logic            regwen,
    input logic [RD_W-1:0] rd,
    input logic [31:0]     wbdata
  );
    return {pc, inst, regwen, rd, wbdata};
  endfunction

endpackage

// File: rtl/cpu_trace_buffer_ram.sv
// trace_ram
// Simple dual-port storage for trace entries: one write port and one
// synchronous read port, written so that it maps onto block RAM.
// Ports:
//   I_clk            clock
//   I_rst            synchronous active-high reset (clears only the read register)
//   I_we/I_waddr/I_wdata  write port
//   I_re/I_raddr     read request; data appears on O_rdata after the edge
//   O_rdata          registered read data, held between reads
module trace_ram
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                     I_clk,
  input  logic                     I_rst,
  input  logic                     I_we,
  input  logic [$clog2(DEPTH)-1:0] I_waddr,
  input  logic [WIDTH-1:0]         I_wdata,
  input  logic                     I_re,
  input  logic [$clog2(DEPTH)-1:0] I_raddr,
  output logic [WIDTH-1:0]         O_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge I_clk) begin
    if (I_we) begin
      r_mem[I_waddr] <= I_wdata;
    end
  end

  // Output register with synchronous reset maps onto the RAM's own output
  // register reset, so the read path stays inside the block RAM.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_rdata <= '0;
    end else if (I_re) begin
      r_rdata <= r_mem[I_raddr];
    end
  end

  assign O_rdata = r_rdata;

endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer
// Records one entry per retired instruction of the RV32 core into a circular
// buffer. Capture keeps pre-trigger history, stops after a programmable
// trigger plus post-trigger window or on a detected halt loop, and then the
// buffer drains oldest-first through a one-entry-per-cycle read port.
// Ports:
//   I_clk, I_rst               clock, synchronous active-high reset
//   I_pc, I_inst, I_regwen, I_rd, I_wbdata, I_memrw, I_aluout
//                              core observation taps
//   I_arm                      start capture (IDLE or DONE only)
//   I_trig_mode, I_trig_value  trigger selection and match value
//   I_post_count               entries captured after the trigger entry
//   I_rd_en                    pop the oldest entry (DONE only)
//   O_rd_data, O_rd_valid      popped entry and its one-cycle valid pulse
//   O_count, O_empty           entries held
//   O_state                    capture state
//   O_halt                     sticky halt-loop flag
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int REG_AW      = 4,
  parameter int HALT_CYCLES = 16
) (
  input  logic                     I_clk,
  input  logic                     I_rst,
  input  logic [31:0]              I_pc,
  input  logic [31:0]              I_inst,
  input  logic                     I_regwen,
  input  logic [REG_AW-1:0]        I_rd,
  input  logic [31:0]              I_wbdata,
  input  logic                     I_memrw,
  input  logic [31:0]              I_aluout,
  input  logic                     I_arm,
  input  logic [1:0]               I_trig_mode,
  input  logic [31:0]              I_trig_value,
  input  logic [$clog2(DEPTH)-1:0] I_post_count,
  input  logic                     I_rd_en,
  output logic [ENTRY_W-1:0]       O_rd_data,
  output logic                     O_rd_valid,
  output logic [$clog2(DEPTH):0]   O_count,
  output logic                     O_empty,
  output logic [1:0]               O_state,
  output logic                     O_halt
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HALT_CYCLES + 1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [HW-1:0] HALT_LAST = HW'(HALT_CYCLES - 1);

  trace_state_e    r_state;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [AW-1:0]   r_post_cnt;
  logic [AW-1:0]   r_post_cfg;
  logic [1:0]      r_trig_mode;
  logic [31:0]     r_trig_value;
  logic [31:0]     r_prev_pc;
  logic            r_prev_valid;
  logic [HW-1:0]   r_halt_cnt;
  logic            r_halt;
  logic            r_rd_valid;

  logic                w_arm_ok;
  logic                w_capture;
  logic                w_pop;
  logic                w_trig_hit;
  logic                w_pc_same;
  logic                w_halt_hit;
  logic [ENTRY_W-1:0]  w_entry;

  assign w_arm_ok  = I_arm && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_capture = (r_state == ST_ARMED) || (r_state == ST_TRIGGERED);
  assign w_pop     = (r_state == ST_DONE) && I_rd_en && (r_count != '0);

  // Match uses the configuration latched at arm time, against this cycle's taps.
  always_comb begin
    w_trig_hit = 1'b0;
    case (r_trig_mode)
      TRIG_IMMEDIATE: w_trig_hit = 1'b1;
      TRIG_PC:        w_trig_hit = (I_pc == r_trig_value);
      TRIG_STORE:     w_trig_hit = I_memrw && (I_aluout == r_trig_value);
      TRIG_REG:       w_trig_hit = I_regwen && (I_rd == r_trig_value[REG_AW-1:0]);
      default:        w_trig_hit = 1'b0;
    endcase
  end

  // The first captured cycle after arm has no predecessor to compare with.
  assign w_pc_same  = r_prev_valid && (I_pc == r_prev_pc);
  assign w_halt_hit = w_pc_same && (r_halt_cnt == HALT_LAST);

  assign w_entry = pack_entry(I_pc, I_inst, I_regwen, RD_W'(I_rd), I_wbdata);

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .I_clk   (I_clk),
    .I_rst   (I_rst),
    .I_we    (w_capture),
    .I_waddr (r_wr_ptr),
    .I_wdata (w_entry),
    .I_re    (w_pop),
    .I_raddr (r_rd_ptr),
    .O_rdata (O_rd_data)
  );

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_post_cnt   <= '0;
      r_post_cfg   <= '0;
      r_trig_mode  <= TRIG_IMMEDIATE;
      r_trig_value <= '0;
      r_prev_pc    <= '0;
      r_prev_valid <= 1'b0;
      r_halt_cnt   <= '0;
      r_halt       <= 1'b0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (w_arm_ok) begin
        // Arming discards whatever is left in the buffer.
        r_state      <= ST_ARMED;
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_count      <= '0;
        r_post_cnt   <= '0;
        r_post_cfg   <= I_post_count;
        r_trig_mode  <= I_trig_mode;
        r_trig_value <= I_trig_value;
        r_prev_valid <= 1'b0;
        r_halt_cnt   <= '0;
        r_halt       <= 1'b0;
      end else begin
        if (w_capture) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          // When full the write lands on the oldest slot, so oldest moves on.
          if (r_count == CNT_FULL) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
          end else begin
            r_count <= r_count + 1'b1;
          end
          r_prev_pc    <= I_pc;
          r_prev_valid <= 1'b1;
          r_halt_cnt   <= w_pc_same ? (r_halt_cnt + HW'(1)) : '0;

          if (w_halt_hit) begin
            // Halt takes priority over a coincident trigger match.
            r_halt  <= 1'b1;
            r_state <= ST_DONE;
          end else if (r_state == ST_ARMED) begin
            if (w_trig_hit) begin
              if (r_post_cfg == '0) begin
                r_state <= ST_DONE;
              end else begin
                r_state    <= ST_TRIGGERED;
                r_post_cnt <= r_post_cfg;
              end
            end
          end else begin
            r_post_cnt <= r_post_cnt - 1'b1;
            if (r_post_cnt == AW'(1)) begin
              r_state <= ST_DONE;
            end
          end
        end

        if (w_pop) begin
          r_rd_ptr   <= r_rd_ptr + 1'b1;
          r_count    <= r_count - 1'b1;
          r_rd_valid <= 1'b1;
        end
      end
    end
  end

  assign O_rd_valid = r_rd_valid;
  assign O_count    = r_count;
  assign O_empty    = (r_count == '0);
  assign O_state    = r_state;
  assign O_halt     = r_halt;

endmodule
